// File: rtl/booth_feeder.sv
// booth_feeder: queues signed 4-bit operand pairs, issues them one at a time
// to an external Booth multiplier, and hands each product to a consumer
// through a valid/ready output. A multiplier that never finishes is abandoned
// after TIMEOUT cycles. That pair is dropped and the sticky err flag is set.
module booth_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_x,
  input  logic [3:0]             in_y,
  output logic                   mul_start,
  output logic [3:0]             mul_x,
  output logic [3:0]             mul_y,
  input  logic                   mul_valid,
  input  logic [7:0]             mul_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_z,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // The wait counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic          up_reg;       // low during reset and for the first edge after it
  logic          mv_prev_reg;  // mul_valid from the previous cycle, for edge detect

  logic          push;
  logic          pop;
  logic          done;
  logic          expire;
  logic          have_next;
  logic [7:0]    head;
  logic [7:0]    next_head;

  assign in_ready   = up_reg && (count_reg != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  // Only a fresh 0->1 transition while waiting counts as completion.
  assign done       = (state_reg == WAIT) && mul_valid && !mv_prev_reg;
  assign expire     = (state_reg == WAIT) && !done && (wait_cnt_reg == TW'(TIMEOUT - 1));
  // The head entry leaves the FIFO when its product is captured or when it is abandoned.
  assign pop        = done || expire;
  assign head       = mem[rptr_reg];
  // When leaving HOLD, a pair being pushed into an empty FIFO this cycle is
  // already the next one to issue. Forward it straight from the input.
  assign have_next  = (count_reg != '0) || push;
  assign next_head  = (count_reg != '0) ? head : {in_x, in_y};
  assign fifo_count = count_reg;

  // Write the accepted pair into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg] <= {in_x, in_y};
    end
  end

  // Move the FIFO pointers and the occupancy count. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Enable acceptance one edge after reset, and track mul_valid for the edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_reg      <= 1'b0;
      mv_prev_reg <= 1'b0;
    end else begin
      up_reg      <= 1'b1;
      mv_prev_reg <= mul_valid;
    end
  end

  // Sequence each pair through issue, wait, and hold. All outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mul_start    <= 1'b0;
      mul_x        <= '0;
      mul_y        <= '0;
      out_valid    <= 1'b0;
      out_z        <= '0;
      err          <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg <= ISSUE;
            mul_start <= 1'b1;
            mul_x     <= head[7:4];
            mul_y     <= head[3:0];
          end
        end
        ISSUE: begin
          state_reg    <= WAIT;
          wait_cnt_reg <= '0;
        end
        WAIT: begin
          if (done) begin
            state_reg <= HOLD;
            out_z     <= mul_z;
            out_valid <= 1'b1;
            mul_x     <= '0;
            mul_y     <= '0;
          end else if (expire) begin
            state_reg <= IDLE;
            err       <= 1'b1;
            mul_x     <= '0;
            mul_y     <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (have_next) begin
              state_reg <= ISSUE;
              mul_start <= 1'b1;
              mul_x     <= next_head[7:4];
              mul_y     <= next_head[3:0];
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_feeder.sv
// Testbench for booth_feeder. A behavioural multiplier responds to mul_start
// after a programmable latency. A scoreboard compares every issued operand pair
// and every delivered product with the order in which the pairs were accepted.
module tb_booth_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       mul_start;
  logic [3:0] mul_x;
  logic [3:0] mul_y;
  logic       mul_valid;
  logic [7:0] mul_z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_z;
  logic [2:0] fifo_count;
  logic       err;

  pair_t      pair_q[$];   // accepted pairs that have not been issued yet
  logic [7:0] prod_q[$];   // products the consumer must still receive, in order
  int         n_chk      = 0;
  int         n_err      = 0;
  int         n_issue_m  = 0;
  int         n_issue_r  = 0;
  int         skip_idx   = -1;  // issue number the multiplier model never answers
  int         mul_lat    = 4;   // 0 selects a random latency for each issue
  int         n_out      = 0;
  logic       prev_start = 1'b0;

  always #5 clk = ~clk;

  booth_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .fifo_count(fifo_count), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. Returns at posedge+1 after the pair has been accepted.
  task automatic push(input logic [3:0] x, input logic [3:0] y);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("push_stall", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(tag, {31'b0, out_valid}, 1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mul_start) break;
    end
    chk(tag, {31'b0, mul_start}, 1);
  endtask

  // Use with out_ready held at 1. Waits for the next handshake and checks the product.
  task automatic take(input string tag, input logic [7:0] exp);
    wait_out({tag, "_v"}, 100);
    chk(tag, {24'b0, out_z}, {24'b0, exp});
  endtask

  task automatic release_out();
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
  endtask

  // Behavioural Booth multiplier: answers each start after a latency with one mul_valid pulse.
  initial begin
    logic signed [3:0] cx;
    logic signed [3:0] cy;
    logic signed [7:0] p;
    int                lat;
    bit                silent;
    mul_valid = 1'b0;
    mul_z     = '0;
    forever begin
      @(negedge clk);
      if (mul_start && !rst) begin
        cx     = mul_x;
        cy     = mul_y;
        silent = (n_issue_r == skip_idx);
        n_issue_r++;
        if (!silent) begin
          lat = (mul_lat > 0) ? mul_lat : int'($urandom_range(1, 8));
          repeat (lat) @(negedge clk);
          p         = cx * cy;
          mul_z     = p;
          mul_valid = 1'b1;
          @(negedge clk);
          mul_valid = 1'b0;
        end
      end
    end
  end

  // Scoreboard: issue order, one-cycle start pulse, product value and order, and no unexpected results.
  always @(negedge clk) begin
    pair_t pr;
    int    pv;
    if (!rst) begin
      if (mul_start) begin
        chk("start_1cyc", {31'b0, prev_start}, 0);
        if (pair_q.size() == 0) begin
          chk("start_unexp", {31'b0, mul_start}, 0);
        end else begin
          pr = pair_q.pop_front();
          chk("mul_x", {28'b0, mul_x}, {28'b0, pr.x});
          chk("mul_y", {28'b0, mul_y}, {28'b0, pr.y});
          if (n_issue_m != skip_idx) begin
            pv = $signed(pr.x) * $signed(pr.y);
            prod_q.push_back(pv[7:0]);
          end
        end
        n_issue_m++;
      end
      if (out_valid) begin
        if (prod_q.size() == 0) begin
          chk("out_unexp", {31'b0, out_valid}, 0);
        end else begin
          chk("out_z", {24'b0, out_z}, {24'b0, prod_q[0]});
          if (out_ready) begin
            $display("out #%0d z=%0d", n_out, $signed(out_z));
            void'(prod_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) pair_q.push_back({in_x, in_y});
    end
    prev_start <= mul_start;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int tgt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  {31'b0, in_ready},   0);
    chk("rst_ms",   {31'b0, mul_start},  0);
    chk("rst_mx",   {28'b0, mul_x},      0);
    chk("rst_my",   {28'b0, mul_y},      0);
    chk("rst_ov",   {31'b0, out_valid},  0);
    chk("rst_oz",   {24'b0, out_z},      0);
    chk("rst_cnt",  {29'b0, fifo_count}, 0);
    chk("rst_err",  {31'b0, err},        0);
    sync();
    rst = 1'b0;
    #1 chk("rdy_pre_edge", {31'b0, in_ready}, 0);
    sync();
    chk("rdy_first_edge", {31'b0, in_ready}, 1);

    // Single pair 5*7 with a 4-cycle multiplier.
    mul_lat = 4;
    push(4'd5, 4'd7);
    wait_start("r33_s", 20);
    chk("r33_mx", {28'b0, mul_x}, 5);
    chk("r33_my", {28'b0, mul_y}, 7);
    @(negedge clk);
    chk("r33_pulse", {31'b0, mul_start}, 0);
    wait_out("r33_v", 40);
    chk("r33_z", {24'b0, out_z}, 32'h23);
    release_out();

    // Negative operand: -4*6.
    mul_lat = 3;
    push(4'hC, 4'd6);
    wait_start("r34_s", 20);
    chk("r34_mx", {28'b0, mul_x}, 32'hC);
    chk("r34_my", {28'b0, mul_y}, 6);
    wait_out("r34_v", 40);
    chk("r34_z", {24'b0, out_z}, 32'hE8);
    release_out();

    // Fill the FIFO back to back while the consumer stalls, then drain it in order.
    sync();
    mul_lat = 4;
    push(4'd5, 4'd7);  chk("r35_c1", {29'b0, fifo_count}, 1);
    push(4'hC, 4'd6);  chk("r35_c2", {29'b0, fifo_count}, 2);
    push(4'h8, 4'h8);  chk("r35_c3", {29'b0, fifo_count}, 3);
    push(4'd7, 4'hF);  chk("r35_c4", {29'b0, fifo_count}, 4);
    chk("r35_full_rdy", {31'b0, in_ready}, 0);
    wait_out("r35_v", 40);
    chk("r35_c_after_pop", {29'b0, fifo_count}, 3);
    sync();
    out_ready = 1'b1;
    take("r35_z0", 8'h23);
    take("r35_z1", 8'hE8);
    take("r35_z2", 8'h40);
    take("r35_z3", 8'hF9);
    sync();
    out_ready = 1'b0;

    // Consumer stalls in HOLD for 10 cycles while another pair is queued.
    mul_lat = 2;
    push(4'd3, 4'd5);
    push(4'd2, 4'd2);
    wait_out("r36_v", 40);
    repeat (10) begin
      @(negedge clk);
      chk("hold_v",  {31'b0, out_valid}, 1);
      chk("hold_z",  {24'b0, out_z},     32'h0F);
      chk("hold_ms", {31'b0, mul_start}, 0);
      chk("hold_mx", {28'b0, mul_x},     0);
    end
    sync();
    out_ready = 1'b1;
    take("r36_z0", 8'h0F);
    take("r36_z1", 8'h04);

    // Random traffic: random operands, producer gaps, multiplier latency and consumer backpressure.
    sync();
    mul_lat = 0;
    tgt     = n_out + 30;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) sync();
          push(4'($urandom), 4'($urandom));
        end
      end
      begin
        for (int c = 0; c < 4000 && n_out < tgt; c++) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    chk("rand_count", n_out, tgt);
    chk("rand_left",  prod_q.size(), 0);
    sync();
    out_ready = 1'b1;

    // The multiplier never answers the first pair. It is abandoned, and the next pair proceeds normally.
    mul_lat  = 3;
    skip_idx = n_issue_m;
    push(4'd3, 4'd3);
    push(4'd2, 4'hD);
    wait_start("r37_s", 20);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err) break;
    end
    chk("tmo_cycles", k, TIMEOUT + 1);
    take("r37_next", 8'hFA);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'b0, err}, 1);

    // Reset while a pair is in WAIT and two more are queued. A late mul_valid edge must be ignored.
    sync();
    mul_lat = 8;
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    push(4'd5, 4'd6);
    wait_start("r38_s", 20);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    pair_q.delete();
    prod_q.delete();
    chk("r38_rdy", {31'b0, in_ready},   0);
    chk("r38_cnt", {29'b0, fifo_count}, 0);
    chk("r38_ms",  {31'b0, mul_start},  0);
    chk("r38_mx",  {28'b0, mul_x},      0);
    chk("r38_my",  {28'b0, mul_y},      0);
    chk("r38_ov",  {31'b0, out_valid},  0);
    chk("r38_oz",  {24'b0, out_z},      0);
    chk("r38_err", {31'b0, err},        0);
    sync();
    sync();
    rst = 1'b0;
    sync();
    chk("r38_rdy_up", {31'b0, in_ready}, 1);
    repeat (15) begin
      @(negedge clk);
      chk("r38_quiet_ov", {31'b0, out_valid}, 0);
      chk("r38_quiet_ms", {31'b0, mul_start}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/booth_feeder.md
BOOTH_FEEDER -- requirements
Module: booth_feeder

Interface
REQ-001 Parameter DEPTH, 4, operand FIFO entries (power of 2, >=2).
REQ-002 Parameter TIMEOUT, 15, max clk cycles spent in WAIT before abort.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  producer offers an operand pair.
REQ-006 in_ready  out  1  feeder accepts the pair this cycle.
REQ-007 in_x, in_y  in  4 each  signed operands.
REQ-008 mul_start  out  1  one-cycle start pulse to the Booth multiplier.
REQ-009 mul_x, mul_y  out  4 each  signed operands to the multiplier.
REQ-010 mul_valid  in  1  multiplier done level.
REQ-011 mul_z  in  8  signed multiplier product.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 out_z  out  8  signed product.
REQ-015 fifo_count  out  clog2(DEPTH)+1  occupied entries.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 The FIFO SHALL store {in_x,in_y} on in_valid && in_ready; in_ready = (fifo_count != DEPTH); read/write pointers wrap modulo DEPTH.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-019 IDLE: FIFO non-empty -> ISSUE; else stay.
REQ-020 ISSUE: mul_start=1 for exactly this one cycle; mul_x/mul_y = FIFO head; -> WAIT.
REQ-021 mul_x/mul_y SHALL hold the head value throughout ISSUE and WAIT, and SHALL be 0 in IDLE/HOLD.
REQ-022 Completion SHALL be a rising edge of mul_valid (registered previous sample 0, current 1) observed in WAIT; a mul_valid that is already high on entry to WAIT is not completion.
REQ-023 On completion: out_z <= mul_z, pop FIFO head, out_valid <= 1, -> HOLD.
REQ-024 HOLD: out_valid=1 and out_z stable until out_ready=1; on out_valid && out_ready -> ISSUE if FIFO non-empty (after any same-cycle push), else IDLE; out_valid drops the next cycle.
REQ-025 WAIT cycle counter SHALL clear on entry; after TIMEOUT cycles without completion: err <= 1, pop head, discard it, -> IDLE, no out_valid.
REQ-026 err SHALL remain 1 until reset.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push when full is impossible (in_ready=0).
REQ-028 Products SHALL emerge in the acceptance order of operand pairs; exactly one out_valid handshake per non-timed-out pair.
REQ-029 out_z SHALL carry mul_z unmodified (8-bit two's complement, no extension or saturation).

Reset
REQ-030 While rst=1: state=IDLE, FIFO empty, fifo_count=0, in_ready=0, mul_start=0, mul_x=mul_y=0, out_valid=0, out_z=0, err=0, counter=0.
REQ-031 in_ready SHALL become 1 on the first clk edge after rst deasserts.
REQ-032 rst asserted in any state (including mid-WAIT) SHALL abort immediately; FIFO contents are lost; any later mul_valid edge from the aborted operation is ignored (treated per REQ-022 only after a new ISSUE).

Verification
REQ-033 Push (5,7); model mul_valid rising 4 cycles after mul_start with mul_z=35 -> single mul_start pulse with mul_x=5,mul_y=7; out_valid=1, out_z=35 (0x23).
REQ-034 Push (-4,6) -> mul_x=0xC, mul_y=6; out_z=-24 (0xE8).
REQ-035 Push 4 pairs back-to-back, out_ready=0 -> fifo_count 1..4 (the first pair pops on completion), in_ready=0 when count=4; releasing out_ready drains all results in order (5*7, -4*6, -8*-8=64, 7*-1=-7).
REQ-036 out_ready held 0 for 10 cycles in HOLD -> out_z and out_valid stable, no new mul_start issued.
REQ-037 Model never raises mul_valid -> err=1 exactly TIMEOUT cycles after WAIT entry, no out_valid, next pair is then issued normally.
REQ-038 rst pulsed mid-WAIT with 2 entries queued -> all outputs at reset values, fifo_count=0; a late mul_valid edge produces no out_valid.
